// File: rtl/comp_pkg.sv
// Shared types and default constants for the board calculator front-end blocks.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam logic [31:0] CLICK_COUNT_DEF = 32'd2500000;
    localparam logic [31:0] INC_COUNT_DEF   = 32'd25000000;

    // The debounced level is high whenever the FSM considers the button down.
    function automatic logic is_held(input btn_state_t st);
        return (st == HELD) || (st == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs; reset value is a parameter.
module sync_2ff #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_click.sv
// Debounced push-button: turns a bouncing active-low pin into single-cycle click pulses
// with auto-repeat while held, plus a debounced pressed level.
module button_click
    import comp_pkg::*;
#(
    parameter logic [31:0] CLICK_COUNT = CLICK_COUNT_DEF,
    parameter logic [31:0] INC_COUNT   = INC_COUNT_DEF
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic click,
    output logic pressed
);

    logic        btn_sync_n;
    logic        s;

    btn_state_t  state_q,      state_d;
    logic [31:0] stable_cnt_q, stable_cnt_d;
    logic [31:0] rep_cnt_q,    rep_cnt_d;
    logic        click_q,      click_d;
    logic        pressed_q,    pressed_d;

    logic [31:0] stable_inc;
    logic [31:0] rep_inc;
    logic        stable_done;
    logic        rep_tick;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     (btn_n),
        .q     (btn_sync_n)
    );

    assign s = ~btn_sync_n;

    assign stable_inc  = stable_cnt_q + 32'd1;
    assign rep_inc     = rep_cnt_q + 32'd1;
    assign stable_done = (stable_inc == CLICK_COUNT);
    assign rep_tick    = (INC_COUNT != 32'd0) && (rep_inc == INC_COUNT);

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        click_d      = 1'b0;

        case (state_q)
            IDLE: begin
                stable_cnt_d = 32'd0;
                if (s) begin
                    state_d      = PRESS_WAIT;
                    stable_cnt_d = 32'd1;
                end
            end

            PRESS_WAIT: begin
                if (!s) begin
                    state_d      = IDLE;
                    stable_cnt_d = 32'd0;
                end else if (stable_done) begin
                    state_d      = HELD;
                    stable_cnt_d = 32'd0;
                    rep_cnt_d    = 32'd0;
                    click_d      = 1'b1;
                end else begin
                    stable_cnt_d = stable_inc;
                end
            end

            HELD: begin
                stable_cnt_d = 32'd0;
                // A repeat tick coinciding with the first release sample still fires.
                if (INC_COUNT != 32'd0) begin
                    rep_cnt_d = rep_tick ? 32'd0 : rep_inc;
                    click_d   = rep_tick;
                end
                if (!s) begin
                    state_d      = RELEASE_WAIT;
                    stable_cnt_d = 32'd1;
                end
            end

            RELEASE_WAIT: begin
                if (s) begin
                    state_d      = HELD;
                    stable_cnt_d = 32'd0;
                    rep_cnt_d    = 32'd0;
                end else if (stable_done) begin
                    state_d      = IDLE;
                    stable_cnt_d = 32'd0;
                end else begin
                    stable_cnt_d = stable_inc;
                end
            end

            default: begin
                state_d      = IDLE;
                stable_cnt_d = 32'd0;
                rep_cnt_d    = 32'd0;
            end
        endcase

        pressed_d = is_held(state_d);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            stable_cnt_q <= 32'd0;
            rep_cnt_q    <= 32'd0;
            click_q      <= 1'b0;
            pressed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            click_q      <= click_d;
            pressed_q    <= pressed_d;
        end
    end

    assign click   = click_q;
    assign pressed = pressed_q;

endmodule

// File: doc/button_click.md
# button_click

Debounced push-button front end for the board calculator: it turns a raw, bouncing, active-low button pin into single-cycle `click` pulses in the `sys_clk` domain, plus a debounced `pressed` level. Holding the button produces auto-repeat clicks, so operand digits can be stepped quickly. One instance sits between each board button and the calculator control logic, which consumes `click` as its "state advance" and "increment" events.

## Interface

- `CLICK_COUNT`, default 32'd2500000: number of consecutive stable synchronized samples required to accept a press or a release. Must be ≥ 2.
- `INC_COUNT`, default 32'd25000000: auto-repeat period in cycles while the button is held. 0 disables auto-repeat. A non-zero value must be ≥ 2.
- `sys_clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `btn_n`  input  1  raw button pin, asynchronous to `sys_clk`; 0 = pressed.
- `click`  output  1  one-cycle pulse per accepted press and per auto-repeat tick.
- `pressed`  output  1  debounced button level; 1 = held.

## Operation

- Input path: 2-flop synchronizer on `btn_n`. Both flops reset to 1 (released). `s` denotes the second flop output, inverted so that 1 = pressed.
- Counters: one 32-bit `stable_cnt` and one 32-bit `rep_cnt`, both unsigned. Neither counter wraps: each is cleared whenever it reaches its terminal value.
- FSM states, held in the shared enum `btn_state_t`:
  - IDLE: `pressed` = 0, `stable_cnt` = 0. On `s` = 1, go to PRESS_WAIT with `stable_cnt` = 1.
  - PRESS_WAIT: if `s` = 0 (bounce), go to IDLE and clear the counter. Otherwise increment. When the count reaches CLICK_COUNT, go to HELD, pulse `click`, and clear `rep_cnt`.
  - HELD: `pressed` = 1. If INC_COUNT ≠ 0, `rep_cnt` increments every cycle; on reaching INC_COUNT it clears to 0 and `click` pulses. On `s` = 0, go to RELEASE_WAIT with `stable_cnt` = 1; `rep_cnt` freezes.
  - RELEASE_WAIT: `pressed` stays 1 and no repeat clicks are issued. If `s` = 1 (bounce), return to HELD, clear `rep_cnt`, and issue no click. Otherwise increment. When the count reaches CLICK_COUNT, go to IDLE and drop `pressed`.
- Simultaneous events: if a repeat tick and a release sample coincide in HELD, the tick wins. `click` pulses and the FSM moves to RELEASE_WAIT in the same cycle.
- Unreachable state encodings recover to IDLE on the next clock edge.

## Timing

- Reset values (asynchronous, immediate): `click` = 0, `pressed` = 0, FSM = IDLE, counters = 0, synchronizer = 1.
- Removal of `rst_n` is synchronized by the system. The first FSM update occurs on the first `sys_clk` edge with `rst_n` = 1.
- Press latency: if `btn_n` is stable low from before edge E0, then `s` = 1 after edge E1 and `click` is high for exactly the one cycle following edge E1+CLICK_COUNT. `pressed` rises on the same edge.
- Repeat: each further `click` occurs INC_COUNT cycles after the previous one while the button is held.
- Release latency: `pressed` falls CLICK_COUNT+1 edges after `btn_n` goes stably high.
- `click` is a registered output, never high for two consecutive cycles, and glitch-free.
- Reset asserted mid-press or mid-repeat aborts immediately; no click is emitted on reset release even if the button is still held, until a full CLICK_COUNT qualification completes.

## Structure

- Shared package `comp_pkg`: `btn_state_t` (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), plus default constants `CLICK_COUNT_DEF` and `INC_COUNT_DEF` used by top-level instantiations.
- Sub-module `sync_2ff`, a generic 2-flop synchronizer with a reset-value parameter, reused for every asynchronous board input.
- `button_click` contains the FSM, the two counters and the output registers.

## Test plan

All scenarios use CLICK_COUNT=4, INC_COUNT=10.

- Clean press, held 6 cycles, then clean release → exactly 1 `click`; `click` high in the cycle after edge 5 counted from the first low sample; `pressed` high until 5 edges after the release.
- Press with bounce (low 2 cycles, high 1, low 3, high) → no `click`; `pressed` stays 0 throughout.
- Hold for 40 cycles → clicks at press+0, +10, +20, +30 (4 pulses); each pulse is 1 cycle wide.
- Release with bounce (high 2 cycles, low 1, then high stable) → `pressed` stays 1 through the bounce; no extra click; `pressed` drops 5 edges after the final rising edge of `btn_n`.
- Assert `rst_n` = 0 while HELD with `rep_cnt` = 7, release it with the button still held → outputs go to 0 immediately; next click comes only after 4 stable samples following reset release.
- INC_COUNT=0, hold for 50 cycles → exactly 1 click.
